// File: rtl/lcd_port_arbiter.sv
// Round-robin two-requester byte sequencer driving a 4-bit character LCD.
// Define LCD_ARB_INIT_EN to send the power-on init table before any requester is served.
module lcd_port_arbiter #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned E_CYC     = 12,
   parameter int unsigned NIB_GAP   = 50,
   parameter int unsigned CMD_WAIT  = 2000,
   parameter int unsigned CLR_WAIT  = 82000,
   parameter int unsigned PWR_WAIT  = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a_valid,
   input  logic       a_rs,
   input  logic [7:0] a_data,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic       b_rs,
   input  logic [7:0] b_data,
   output logic       b_ready,
   output logic       busy,
   output logic       sf_e,
   output logic       e,
   output logic       rs,
   output logic       rw,
   output logic [3:0] d
);

   typedef enum logic [3:0] {
      S_PWR, S_INIT, S_IDLE, S_SET_H, S_EN_H, S_GAP, S_SET_L, S_EN_L, S_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic        brs_q, brs_d;
   logic        long_q, long_d;
   logic        nib_q, nib_d;
   logic        ptr_q, ptr_d;
   logic        e_q, e_d;
   logic        rs_q, rs_d;
   logic [3:0]  d_q, d_d;
   logic        a_grant, b_grant;

   function automatic logic is_clr(input logic r, input logic [7:0] b);
      return !r && (b == 8'h01 || b == 8'h02);
   endfunction

   // Counter value loaded on entry so that each timed state lasts exactly its parameter.
   function automatic logic [19:0] load_for(input state_t s, input logic lng);
      case (s)
         S_SET_H, S_SET_L: load_for = 20'(SETUP_CYC - 1);
         S_EN_H, S_EN_L:   load_for = 20'(E_CYC - 1);
         S_GAP:            load_for = 20'(NIB_GAP - 1);
         S_WAIT:           load_for = lng ? 20'(CLR_WAIT - 1) : 20'(CMD_WAIT - 1);
         default:          load_for = '0;
      endcase
   endfunction

`ifdef LCD_ARB_INIT_EN
   logic [3:0] idx_q, idx_d;
   logic [8:0] ent;

   // Entry format {nibble_only, byte}; nibble-only entries carry their nibble in bits 7:4.
   always_comb begin
      case (idx_q[2:0])
         3'd0, 3'd1, 3'd2: ent = 9'h130;
         3'd3:             ent = 9'h120;
         3'd4:             ent = 9'h028;
         3'd5:             ent = 9'h006;
         3'd6:             ent = 9'h00C;
         default:          ent = 9'h001;
      endcase
   end
`endif

   assign a_ready = (state_q == S_IDLE) && (!ptr_q || !b_valid);
   assign b_ready = (state_q == S_IDLE) && (ptr_q || !a_valid);
   assign a_grant = a_valid && a_ready;
   assign b_grant = b_valid && b_ready && !a_grant;

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 20'd1 : cnt_q;
      byte_d  = byte_q;
      brs_d   = brs_q;
      long_d  = long_q;
      nib_d   = nib_q;
      ptr_d   = ptr_q;
`ifdef LCD_ARB_INIT_EN
      idx_d   = idx_q;
`endif
      case (state_q)
         S_PWR: if (cnt_q == '0) begin
`ifdef LCD_ARB_INIT_EN
            state_d = S_INIT;
`else
            state_d = S_IDLE;
`endif
         end
`ifdef LCD_ARB_INIT_EN
         S_INIT: begin
            byte_d  = ent[7:0];
            brs_d   = 1'b0;
            nib_d   = ent[8];
            long_d  = ent[8] || is_clr(1'b0, ent[7:0]);
            idx_d   = idx_q + 4'd1;
            state_d = S_SET_H;
         end
`endif
         S_IDLE: begin
            if (a_grant) begin
               byte_d  = a_data;
               brs_d   = a_rs;
               ptr_d   = 1'b1;
               state_d = S_SET_H;
            end else if (b_grant) begin
               byte_d  = b_data;
               brs_d   = b_rs;
               ptr_d   = 1'b0;
               state_d = S_SET_H;
            end
            nib_d  = 1'b0;
            long_d = is_clr(brs_d, byte_d);
         end
         S_SET_H: if (cnt_q == '0) state_d = S_EN_H;
         S_EN_H:  if (cnt_q == '0) state_d = nib_q ? S_WAIT : S_GAP;
         S_GAP:   if (cnt_q == '0) state_d = S_SET_L;
         S_SET_L: if (cnt_q == '0) state_d = S_EN_L;
         S_EN_L:  if (cnt_q == '0) state_d = S_WAIT;
         S_WAIT: if (cnt_q == '0) begin
`ifdef LCD_ARB_INIT_EN
            state_d = (idx_q != 4'd8) ? S_INIT : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) cnt_d = load_for(state_d, long_d);

      // Pins are registered from the next state so d leads e by the full setup time.
      e_d  = (state_d == S_EN_H) || (state_d == S_EN_L);
      rs_d = rs_q;
      d_d  = d_q;
      if (state_d == S_SET_H) begin
         rs_d = brs_d;
         d_d  = byte_d[7:4];
      end else if (state_d == S_SET_L) begin
         d_d  = byte_d[3:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_PWR;
         cnt_q   <= 20'(PWR_WAIT);
         byte_q  <= '0;
         brs_q   <= 1'b0;
         long_q  <= 1'b0;
         nib_q   <= 1'b0;
         ptr_q   <= 1'b0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         brs_q   <= brs_d;
         long_q  <= long_d;
         nib_q   <= nib_d;
         ptr_q   <= ptr_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         d_q     <= d_d;
      end
   end

`ifdef LCD_ARB_INIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx_q <= '0;
      else        idx_q <= idx_d;
   end
`endif

   assign e    = e_q;
   assign rs   = rs_q;
   assign d    = d_q;
   assign rw   = 1'b0;
   assign sf_e = 1'b1;
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Self-checking bench for lcd_port_arbiter: nibble scoreboard on every e pulse plus
// table-driven single-byte vectors and hand-written arbitration/reset sequences.
module tb_lcd_port_arbiter;

   localparam int SETUP = 2;
   localparam int ECYC  = 3;
   localparam int GAP   = 4;
   localparam int CMDW  = 10;
   localparam int CLRW  = 30;
   localparam int PWRW  = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       aValid = 1'b0, aRs = 1'b0, bValid = 1'b0, bRs = 1'b0;
   logic [7:0] aData = 8'h00, bData = 8'h00;
   logic       aReady, bReady, busy, sfE, e, rs, rw;
   logic [3:0] d;

   int         checks = 0;
   int         fails = 0;
   logic       ptrModel = 1'b0;
   logic [4:0] sbQ [$];

   typedef struct {
      logic       who;
      logic       rs;
      logic [7:0] data;
      int         expOcc;
   } vec_t;
   vec_t vecs [6];

   lcd_port_arbiter #(
      .SETUP_CYC(SETUP), .E_CYC(ECYC), .NIB_GAP(GAP),
      .CMD_WAIT(CMDW), .CLR_WAIT(CLRW), .PWR_WAIT(PWRW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(aValid), .a_rs(aRs), .a_data(aData), .a_ready(aReady),
      .b_valid(bValid), .b_rs(bRs), .b_data(bData), .b_ready(bReady),
      .busy(busy), .sf_e(sfE), .e(e), .rs(rs), .rw(rw), .d(d)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic pushByte(input logic r, input logic [7:0] b);
      sbQ.push_back({r, b[7:4]});
      sbQ.push_back({r, b[3:0]});
   endtask

   // Every rising e pops one expected {rs,nibble}; pulse width and pin hold are checked on the fall.
   logic       ePrev = 1'b0;
   int         pulseLen = 0;
   int         holdErr = 0;
   logic [4:0] held = '0;
   logic [4:0] expNib;
   always @(negedge clk) begin
      if (!rst_n) begin
         ePrev    = 1'b0;
         pulseLen = 0;
         holdErr  = 0;
      end else begin
         if (e && !ePrev) begin
            if (sbQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected-e-pulse: got rs/d 0x%0h, want no pulse", {rs, d});
            end else begin
               expNib = sbQ.pop_front();
               checkOutput("nibble", {59'd0, rs, d}, {59'd0, expNib});
            end
            held     = {rs, d};
            pulseLen = 1;
            holdErr  = 0;
         end else if (e) begin
            pulseLen++;
            if ({rs, d} !== held) holdErr++;
         end else if (ePrev) begin
            if ({rs, d} !== held) holdErr++;
            checkOutput("e-high-cycles", 64'(pulseLen), 64'(ECYC));
            checkOutput("d-rs-held-around-e", 64'(holdErr), 64'd0);
         end
         ePrev = e;
      end
   end

   task automatic powerUp();
      int n;
      int early;
      int expN;
      logic [3:0] initNibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                    4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
      ptrModel = 1'b0;
      sbQ.delete();
`ifdef LCD_ARB_INIT_EN
      foreach (initNibs[i]) sbQ.push_back({1'b0, initNibs[i]});
      expN = PWRW + 1 + 4 * (1 + SETUP + ECYC + CLRW)
           + 3 * (1 + 2 * (SETUP + ECYC) + GAP + CMDW)
           + (1 + 2 * (SETUP + ECYC) + GAP + CLRW);
`else
      expN = PWRW + 1;
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;
      n = 0;
      early = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
         if (n <= PWRW && e) early++;
      end while (!aReady && n < 2000);
      checkOutput("power-up-ready-cycle", 64'(n), 64'(expN));
      checkOutput("no-e-during-pwr", 64'(early), 64'd0);
      checkOutput("init-queue-drained", 64'(sbQ.size()), 64'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      int n;
      logic [63:0] expE, actE;
      logic expA, expB;
      @(negedge clk);
      if (v.who) begin
         bValid = 1'b1; bRs = v.rs; bData = v.data;
      end else begin
         aValid = 1'b1; aRs = v.rs; aData = v.data;
      end
      #1;
      expA = !ptrModel || !bValid;
      expB = ptrModel || !aValid;
      checkOutput("a_ready-on-request", {63'd0, aReady}, {63'd0, expA});
      checkOutput("b_ready-on-request", {63'd0, bReady}, {63'd0, expB});
      @(posedge clk);
      pushByte(v.rs, v.data);
      ptrModel = !v.who;
      @(negedge clk);
      aValid = 1'b0;
      bValid = 1'b0;
      #1;
      checkOutput("busy-after-accept", {63'd0, busy}, 64'd1);
      n = 1;
      actE = '0;
      while (!(aReady || bReady) && n < 200) begin
         if (n < 64) actE[n] = e;
         @(negedge clk);
         #1;
         n++;
      end
      expE = '0;
      for (int k = 1; k < 64 && k < v.expOcc; k++)
         expE[k] = (k >= 1 + SETUP && k <= SETUP + ECYC) ||
                   (k >= 1 + 2 * SETUP + ECYC + GAP && k <= 2 * (SETUP + ECYC) + GAP);
      checkOutput("occupancy", 64'(n), 64'(v.expOcc));
      checkOutput("e-waveform", actE, expE);
   endtask

   // Both requesters hold valid continuously; grants must alternate starting from the pointer.
   task automatic streamBoth();
      logic [7:0] aItems [3] = '{8'h11, 8'h12, 8'h13};
      logic [7:0] bItems [2] = '{8'h21, 8'h22};
      int ai = 0;
      int bi = 0;
      int guard;
      logic expA, expB, grantA;
      @(negedge clk);
      while (ai < 3 || bi < 2) begin
         aValid = (ai < 3);
         bValid = (bi < 2);
         aRs = 1'b1;
         bRs = 1'b1;
         if (ai < 3) aData = aItems[ai];
         if (bi < 2) bData = bItems[bi];
         #1;
         guard = 0;
         while (!(aReady || bReady) && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
         end
         checkOutput("stream-ready-seen", {63'd0, aReady || bReady}, 64'd1);
         if (!(aReady || bReady)) break;
         expA = !ptrModel || !bValid;
         expB = ptrModel || !aValid;
         checkOutput("stream-a_ready", {63'd0, aReady}, {63'd0, expA});
         checkOutput("stream-b_ready", {63'd0, bReady}, {63'd0, expB});
         checkOutput("ready-exclusive", {63'd0, aReady && bReady}, 64'd0);
         grantA = aValid && expA;
         @(posedge clk);
         if (grantA) begin
            pushByte(1'b1, aItems[ai]);
            ai++;
            ptrModel = 1'b1;
         end else begin
            pushByte(1'b1, bItems[bi]);
            bi++;
            ptrModel = 1'b0;
         end
         @(negedge clk);
      end
      aValid = 1'b0;
      bValid = 1'b0;
      #1;
      guard = 0;
      while (!(aReady || bReady) && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      checkOutput("stream-drained", 64'(sbQ.size()), 64'd0);
   endtask

   task automatic midByteReset();
      @(negedge clk);
      aValid = 1'b1; aRs = 1'b1; aData = 8'h5A;
      @(posedge clk);
      pushByte(1'b1, 8'h5A);
      ptrModel = 1'b1;
      @(negedge clk);
      aValid = 1'b0;
      for (int k = 1; k < 13; k++) @(negedge clk);
      #1;
      checkOutput("e-high-in-lower-nibble", {63'd0, e}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async-reset-e", {63'd0, e}, 64'd0);
      checkOutput("async-reset-d", {60'd0, d}, 64'd0);
      checkOutput("async-reset-rs", {63'd0, rs}, 64'd0);
      checkOutput("async-reset-busy", {63'd0, busy}, 64'd1);
      checkOutput("async-reset-a_ready", {63'd0, aReady}, 64'd0);
      checkOutput("queue-at-reset", 64'(sbQ.size()), 64'd0);
      repeat (3) @(negedge clk);
      powerUp();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{who: 1'b0, rs: 1'b1, data: 8'h43, expOcc: 25};
      vecs[1] = '{who: 1'b1, rs: 1'b0, data: 8'h01, expOcc: 45};
      vecs[2] = '{who: 1'b1, rs: 1'b1, data: 8'h01, expOcc: 25};
      vecs[3] = '{who: 1'b0, rs: 1'b0, data: 8'h02, expOcc: 45};
      vecs[4] = '{who: 1'b0, rs: 1'b0, data: 8'h03, expOcc: 25};
      vecs[5] = '{who: 1'b1, rs: 1'b1, data: 8'hA5, expOcc: 25};

      #12;
      checkOutput("reset-e", {63'd0, e}, 64'd0);
      checkOutput("reset-rs", {63'd0, rs}, 64'd0);
      checkOutput("reset-rw", {63'd0, rw}, 64'd0);
      checkOutput("reset-d", {60'd0, d}, 64'd0);
      checkOutput("reset-sf_e", {63'd0, sfE}, 64'd1);
      checkOutput("reset-busy", {63'd0, busy}, 64'd1);
      checkOutput("reset-a_ready", {63'd0, aReady}, 64'd0);
      checkOutput("reset-b_ready", {63'd0, bReady}, 64'd0);

      powerUp();
      foreach (vecs[i]) applyStimulus(vecs[i]);
      streamBoth();
      midByteReset();
      applyStimulus(vecs[0]);

      repeat (5) @(negedge clk);
      #1;
      checkOutput("final-queue-empty", 64'(sbQ.size()), 64'd0);
      checkOutput("final-rw", {63'd0, rw}, 64'd0);
      checkOutput("final-sf_e", {63'd0, sfE}, 64'd1);
      checkOutput("final-idle", {63'd0, busy}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/lcd_port_arbiter.md
# lcd_port_arbiter

Sequencer and two-requester arbiter for the 4-bit character-LCD interface on the 50 MHz board clock. It accepts whole command/data bytes from two independent requesters over valid/ready handshakes, chooses between them round-robin, and drives the LCD pins. Each byte is split into upper and lower nibbles, with enable pulses and post-command waits generated from counters. It replaces the free-running count-decoded LCD drivers and sits between application logic (status/text writers) and the LCD pins.

## Interface
- `SETUP_CYC`, default 2: cycles that rs/data are stable before `e` rises.
- `E_CYC`, default 12: cycles that `e` is held high (≥240 ns).
- `NIB_GAP`, default 50: idle cycles between the upper and lower nibble (1 µs).
- `CMD_WAIT`, default 2000: idle cycles after a normal byte (40 µs).
- `CLR_WAIT`, default 82000: idle cycles after a clear (0x01) or home (0x02) command, rs=0 (1.64 ms).
- `PWR_WAIT`, default 750000: idle cycles after reset before the init sequence starts (15 ms). All parameters are in [1, 2^20−1].
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `a_valid` in 1: requester A has a byte.
- `a_rs` in 1: A register select (1 = data, 0 = command).
- `a_data` in 8: A byte.
- `a_ready` out 1: A byte accepted when `a_valid & a_ready`.
- `b_valid`, `b_rs`, `b_data`, `b_ready`: same as A, for requester B.
- `busy` out 1: high whenever the block is not in IDLE.
- `sf_e` out 1: LCD/StrataFlash select; always 1 after reset.
- `e`, `rs`, `rw` out 1 each: LCD enable, register select, read/write. `rw` is always 0.
- `d` out 4: LCD nibble; bit 3 is the MSB.

## Operation
- **States:** PWR, INIT, IDLE, SET_H, EN_H, GAP, SET_L, EN_L, WAIT. A single 20-bit down-counter times every state.
- **Reset:** state=PWR, counter=`PWR_WAIT`, `e`=0, `rs`=0, `rw`=0, `d`=0, `sf_e`=1, `busy`=1, `a_ready`=`b_ready`=0, round-robin pointer=A.
- **PWR:** wait until the counter reaches 0, then go to INIT (or IDLE when init is compiled out; see Configuration).
- **INIT:** send a fixed table through the same nibble path as requester bytes.
  - Nibble-only entries 0x3, 0x3, 0x3, 0x2: rs=0. Each uses SET/EN timing, then waits `CLR_WAIT`; there is no lower nibble.
  - Full bytes, rs=0: 0x28, 0x06, 0x0C, 0x01. The last of these waits `CLR_WAIT`.
  - After the table completes, go to IDLE.
- **IDLE:** `a_ready`/`b_ready` are combinational from registered state.
  - `a_ready` = IDLE & (ptr==A | !b_valid).
  - `b_ready` = IDLE & (ptr==B | !a_valid).
  - Only one grant can occur per cycle. On a grant, latch {rs, data} and set ptr to the other requester.
  - A lone valid requester is granted every time it asks, regardless of ptr.
- **SET_H:** drive `rs` and `d`=data[7:4] with `e`=0 for `SETUP_CYC` cycles.
- **EN_H:** `e`=1 for `E_CYC` cycles.
- **GAP:** `e`=0 with `d`/`rs` held for `NIB_GAP` cycles.
- **SET_L → EN_L:** same sequence with `d`=data[3:0].
- **WAIT:** `e`=0 for `CLR_WAIT` cycles if rs=0 and data ∈ {0x01, 0x02}, otherwise `CMD_WAIT` cycles. Then go to IDLE.
- **Request stability:** requesters hold `valid`/`rs`/`data` until they see ready. Deasserting `valid` before acceptance is allowed and drops the request with no side effect.
- **Reset during any state:** outputs return to their reset values immediately. Any in-flight byte is lost, and the full PWR and INIT sequence reruns.

## Timing
- All LCD outputs are registered.
- Acceptance at IDLE cycle *t* → `d` shows the upper nibble at *t*+1.
- `e` rises at *t*+1+`SETUP_CYC` and falls after `E_CYC` high cycles.
- The lower-nibble `e` rises at *t*+1+2·`SETUP_CYC`+`E_CYC`+`NIB_GAP`.
- Next ready: total occupancy per byte is 1+2·(`SETUP_CYC`+`E_CYC`)+`NIB_GAP`+wait cycles. Ready next asserts in the cycle after WAIT expires.
- `d`/`rs` never change while `e`=1 or in the cycle `e` falls.
- Maximum throughput: one byte per occupancy period.

## Configuration
- **`LCD_ARB_INIT_EN` defined:** PWR is followed by INIT, and the full power-on sequence is sent before any requester is served.
- **Not defined:** the INIT state and table are removed, and PWR goes directly to IDLE. Software (a requester) is then responsible for the init bytes; 4-bit mode must already be established.

## Test plan
Benches override parameters to `SETUP_CYC`=2, `E_CYC`=3, `NIB_GAP`=4, `CMD_WAIT`=10, `CLR_WAIT`=30, `PWR_WAIT`=20.

- **Init sequence:** with `LCD_ARB_INIT_EN`, release reset.
  - Required: no `e` pulse for 20 cycles.
  - Then `e` pulses carry `d` = 3, 3, 3, 2, 2, 8, 0, 6, 0, C, 0, 1, all with rs=0.
  - `a_ready` is 0 until the final 30-cycle wait ends.
- **Single byte:** A sends rs=1, 0x43.
  - Required: `d`=4 for 5 cycles with `e` high for 3 of them.
  - Then a 4-cycle gap, then `d`=3 with the same timing.
  - `a_ready` returns after 10 wait cycles; total occupancy 25 cycles.
- **Simultaneous requests:** A and B valid together from IDLE with ptr=A.
  - Required: A is served first, then B, then A, strictly alternating.
  - `a_ready` and `b_ready` are never both high.
- **Clear wait:** B sends rs=0, 0x01.
  - Required: 30 wait cycles, not 10, before the next ready.
  - The same byte with rs=1 waits 10 cycles.
- **Mid-byte reset:** assert `rst_n`=0 during EN_L.
  - Required: `e`=0 and `d`=0 in the same cycle (asynchronous).
  - After release, the 20-cycle PWR wait and full init rerun.
  - The interrupted byte is never completed.
- **Macro off:** without `LCD_ARB_INIT_EN`, `a_ready` rises 21 cycles after reset release with no prior `e` pulse.
